svc_rv_div_iter: RTL and testbench

// Iterative RISC-V M-extension divider (DIV/DIVU/REM/REMU) for the EX stage.

---
 rtl/svc_rv_div_iter.sv | 136 +++++++++++++
 tb/tb_svc_rv_div_iter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_rv_div_iter.sv
// rtl/svc_rv_div_iter.sv - iterative RISC-V DIV/DIVU/REM/REMU unit with valid/ready handshake
module svc_rv_div_iter #(
  parameter int XLEN  = 32,
  parameter int BPC   = 1,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [1:0]       op,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  input  logic [TAG_W-1:0] s_tag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [XLEN-1:0]  m_result,
  output logic [TAG_W-1:0] m_tag,
  output logic             busy
);

  localparam int N  = XLEN / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   LAST    = CW'(N - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic            accept, fast, div_zero, ovf;
  logic            is_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs, fast_res;
  logic [XLEN-1:0] quo, rem, dsor;
  logic [CW-1:0]   cnt;
  logic            neg_q, neg_r, sel_rem;
  logic [XLEN-1:0] quo_step, rem_step, q_fin, r_fin;
  logic [XLEN:0]   part;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & dividend[XLEN-1];
  assign b_neg     = is_signed & divisor[XLEN-1];
  assign a_abs     = a_neg ? -dividend : dividend;
  assign b_abs     = b_neg ? -divisor : divisor;
  assign div_zero  = (divisor == '0);
  assign ovf       = is_signed && (dividend == MIN_NEG) && (divisor == '1);
  assign fast      = div_zero | ovf;

  // Divide-by-zero and signed overflow resolve without iterating.
  always_comb begin
    fast_res = '0;
    if (div_zero) fast_res = op[1] ? dividend : '1;
    else          fast_res = op[1] ? '0 : dividend;
  end

  assign accept  = s_valid & s_ready & ~flush;
  assign busy    = (state != IDLE);
  assign m_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (accept) state_nxt = fast ? DONE : CALC;
      end
      CALC: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        s_ready = m_ready;
        if (accept)       state_nxt = fast ? DONE : CALC;
        else if (m_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
    if (rst)   s_ready   = 1'b0;
  end

  // BPC restoring steps per cycle; quo shifts out dividend bits and shifts in quotient bits.
  always_comb begin
    quo_step = quo;
    rem_step = rem;
    part     = '0;
    for (int i = 0; i < BPC; i++) begin
      part     = {rem_step, quo_step[XLEN-1]};
      quo_step = {quo_step[XLEN-2:0], 1'b0};
      if (part >= {1'b0, dsor}) begin
        part        = part - {1'b0, dsor};
        quo_step[0] = 1'b1;
      end
      rem_step = part[XLEN-1:0];
    end
  end

  assign q_fin = neg_q ? -quo_step : quo_step;
  assign r_fin = neg_r ? -rem_step : rem_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_result <= '0;
      m_tag    <= '0;
      quo      <= '0;
      rem      <= '0;
      dsor     <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      sel_rem  <= 1'b0;
    end else if (accept) begin
      m_tag   <= s_tag;
      quo     <= a_abs;
      rem     <= '0;
      dsor    <= b_abs;
      cnt     <= '0;
      neg_q   <= a_neg ^ b_neg;
      neg_r   <= a_neg;
      sel_rem <= op[1];
      if (fast) m_result <= fast_res;
    end else if (state == CALC && !flush) begin
      quo <= quo_step;
      rem <= rem_step;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) m_result <= sel_rem ? r_fin : q_fin;
    end
  end

endmodule

// File: tb/tb_svc_rv_div_iter.sv
// tb/tb_svc_rv_div_iter.sv - bench for svc_rv_div_iter at BPC 1, 2 and 4 against an arithmetic model
module tb_svc_rv_div_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush [3];
  logic        s_valid [3];
  logic        s_ready [3];
  logic [1:0]  op [3];
  logic [31:0] dividend [3];
  logic [31:0] divisor [3];
  logic [4:0]  s_tag [3];
  logic        m_valid [3];
  logic        m_ready [3];
  logic [31:0] m_result [3];
  logic [4:0]  m_tag [3];
  logic        busy [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    svc_rv_div_iter #(.XLEN(32), .BPC(1 << g), .TAG_W(5)) u_dut (
      .clk(clk), .rst(rst), .flush(flush[g]),
      .s_valid(s_valid[g]), .s_ready(s_ready[g]), .op(op[g]),
      .dividend(dividend[g]), .divisor(divisor[g]), .s_tag(s_tag[g]),
      .m_valid(m_valid[g]), .m_ready(m_ready[g]), .m_result(m_result[g]),
      .m_tag(m_tag[g]), .busy(busy[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 0;
  bit rdone = 0;

  // Model state: each divider holds at most one op between accept and result handshake.
  bit          pend [3];
  logic [31:0] e_res [3];
  logic [4:0]  e_tag [3];
  int          due [3];
  bit          e_srdy [3];
  int          n_acc [3], n_ret [3], n_drop [3];

  function automatic logic [31:0] ref_res(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a; r = 32'd0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b; r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  function automatic int ref_lat(int i, logic [1:0] o, logic [31:0] a, logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return (32 >> i) + 1;
  endfunction

  task automatic chk(int i, string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] cyc=%0d: got %h expected %h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic timeout(int i, string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s[%0d] cyc=%0d: timed out waiting", nm, i, cyc);
  endtask

  // Compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    bit emv;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        emv = pend[i] && (cyc >= due[i]);
        e_srdy[i] = !rst && (!pend[i] || (emv && m_ready[i]));
        chk(i, "busy", 32'(busy[i]), 32'(pend[i]));
        chk(i, "s_ready", 32'(s_ready[i]), 32'(e_srdy[i]));
        chk(i, "m_valid", 32'(m_valid[i]), 32'(emv));
        if (emv) begin
          chk(i, "m_result", m_result[i], e_res[i]);
          chk(i, "m_tag", 32'(m_tag[i]), 32'(e_tag[i]));
          if (m_ready[i] && !flush[i] && !rst) begin
            pend[i] = 0;
            n_ret[i]++;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || flush[i]) begin
        if (pend[i]) n_drop[i]++;
        pend[i] = 0;
      end else if (chk_en && s_valid[i] && e_srdy[i]) begin
        pend[i]  = 1;
        e_res[i] = ref_res(op[i], dividend[i], divisor[i]);
        e_tag[i] = s_tag[i];
        due[i]   = cyc + ref_lat(i, op[i], dividend[i], divisor[i]);
        n_acc[i]++;
      end
    end
    cyc++;
  end

  task automatic issue(int i, logic [1:0] o, logic [31:0] a, logic [31:0] b, logic [4:0] t,
                       output int acyc);
    int n = 0;
    op[i] = o; dividend[i] = a; divisor[i] = b; s_tag[i] = t; s_valid[i] = 1'b1;
    #1;
    while (!s_ready[i] && n < 100) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 100) timeout(i, "issue");
    acyc = cyc;
    @(posedge clk); #2;
    s_valid[i] = 1'b0;
  endtask

  task automatic wait_res(int i, int acyc, output logic [31:0] res, output logic [4:0] tag,
                          output int lat);
    int n = 0;
    while (!m_valid[i] && n < 100) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 100) timeout(i, "wait_res");
    lat = cyc - acyc;
    res = m_result[i];
    tag = m_tag[i];
  endtask

  task automatic take(int i);
    m_ready[i] = 1'b1;
    @(posedge clk); #2;
    m_ready[i] = 1'b0;
  endtask

  task automatic run_check(int i, logic [1:0] o, logic [31:0] a, logic [31:0] b, logic [4:0] t,
                           logic [31:0] x_res, int x_lat);
    int ac, lat;
    logic [31:0] r;
    logic [4:0] tg;
    issue(i, o, a, b, t, ac);
    wait_res(i, ac, r, tg, lat);
    chk(i, "lit_res", r, x_res);
    chk(i, "lit_tag", 32'(tg), 32'(t));
    chk(i, "lit_lat", 32'(lat), 32'(x_lat));
    take(i);
  endtask

  task automatic rand_drv(int i, int nops);
    for (int k = 0; k < nops; k++) begin
      int n;
      bit acc;
      logic [31:0] a, b;
      int sel;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #2;
      end
      if ($urandom_range(0, 99) == 0) begin
        flush[i] = 1'b1;
        @(posedge clk); #2;
        flush[i] = 1'b0;
      end
      sel = int'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      case (sel)
        1: b = 32'd0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: begin
          a = 32'($urandom_range(0, 200));
          b = 32'($urandom_range(1, 15));
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        4: b = ($urandom_range(0, 1) == 1) ? 32'd1 : 32'hFFFF_FFFF;
        5: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      op[i] = 2'($urandom_range(0, 3));
      dividend[i] = a;
      divisor[i] = b;
      s_tag[i] = 5'($urandom_range(0, 31));
      s_valid[i] = 1'b1;
      n = 0;
      acc = 0;
      while (!acc && n < 300) begin
        @(negedge clk);
        acc = s_ready[i];
        @(posedge clk); #2;
        n++;
      end
      if (!acc) timeout(i, "rand_accept");
      s_valid[i] = 1'b0;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ac, lat;
    logic [31:0] r;
    logic [4:0] tg;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush[i] = 0; s_valid[i] = 0; op[i] = 0; dividend[i] = 0; divisor[i] = 0;
      s_tag[i] = 0; m_ready[i] = 0; pend[i] = 0; e_srdy[i] = 0;
      n_acc[i] = 0; n_ret[i] = 0; n_drop[i] = 0; due[i] = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1;
    @(posedge clk); #2;
    for (int i = 0; i < 3; i++) begin
      chk(i, "rst_result", m_result[i], 32'd0);
      chk(i, "rst_tag", 32'(m_tag[i]), 32'd0);
      chk(i, "rst_sready", 32'(s_ready[i]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #2;

    run_check(0, 2'b01, 32'd9, 32'd7, 5'd19, 32'd1, 33);
    run_check(1, 2'b00, -32'd20, 32'd4, 5'd1, 32'hFFFF_FFFB, 17);
    run_check(1, 2'b10, -32'd20, 32'd3, 5'd2, 32'hFFFF_FFFE, 17);
    run_check(0, 2'b00, 32'd42, 32'd0, 5'd5, 32'hFFFF_FFFF, 1);
    run_check(0, 2'b11, 32'd42, 32'd0, 5'd6, 32'd42, 1);
    run_check(0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1);
    run_check(2, 2'b11, 32'd100, 32'd7, 5'd8, 32'd2, 9);

    // Result held under backpressure, then a zero-bubble back-to-back accept.
    issue(0, 2'b01, 32'd100, 32'd7, 5'd3, ac);
    wait_res(0, ac, r, tg, lat);
    for (int k = 0; k < 5; k++) begin
      chk(0, "hold_valid", 32'(m_valid[0]), 32'd1);
      chk(0, "hold_result", m_result[0], 32'd14);
      chk(0, "hold_tag", 32'(m_tag[0]), 32'd3);
      @(posedge clk); #2;
    end
    m_ready[0] = 1'b1;
    #1;
    chk(0, "b2b_sready", 32'(s_ready[0]), 32'd1);
    issue(0, 2'b01, 32'd50, 32'd5, 5'd4, ac);
    m_ready[0] = 1'b0;
    chk(0, "b2b_busy", 32'(busy[0]), 32'd1);
    chk(0, "b2b_valid", 32'(m_valid[0]), 32'd0);
    wait_res(0, ac, r, tg, lat);
    chk(0, "b2b_result", r, 32'd10);
    chk(0, "b2b_tag", 32'(tg), 32'd4);
    chk(0, "b2b_lat", 32'(lat), 32'd33);
    take(0);

    // Flush mid-iteration, flush racing an accept, reset mid-iteration.
    issue(0, 2'b01, 32'd1000, 32'd3, 5'd7, ac);
    repeat (10) begin
      @(posedge clk); #2;
    end
    flush[0] = 1'b1;
    @(posedge clk); #2;
    flush[0] = 1'b0;
    chk(0, "flush_busy", 32'(busy[0]), 32'd0);
    chk(0, "flush_valid", 32'(m_valid[0]), 32'd0);
    op[0] = 2'b01; dividend[0] = 32'd5; divisor[0] = 32'd1; s_tag[0] = 5'd8;
    flush[0] = 1'b1; s_valid[0] = 1'b1;
    @(posedge clk); #2;
    flush[0] = 1'b0; s_valid[0] = 1'b0;
    chk(0, "flush_drop_busy", 32'(busy[0]), 32'd0);
    repeat (2) begin
      @(posedge clk); #2;
    end
    chk(0, "flush_drop_valid", 32'(m_valid[0]), 32'd0);
    issue(0, 2'b01, 32'd77, 32'd2, 5'd9, ac);
    repeat (5) begin
      @(posedge clk); #2;
    end
    rst = 1'b1;
    @(posedge clk); #2;
    chk(0, "mrst_valid", 32'(m_valid[0]), 32'd0);
    chk(0, "mrst_result", m_result[0], 32'd0);
    chk(0, "mrst_tag", 32'(m_tag[0]), 32'd0);
    chk(0, "mrst_busy", 32'(busy[0]), 32'd0);
    chk(0, "mrst_sready", 32'(s_ready[0]), 32'd0);
    rst = 1'b0;
    @(posedge clk); #2;

    fork
      begin
        fork
          rand_drv(0, 667);
          rand_drv(1, 667);
          rand_drv(2, 666);
        join
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          for (int i = 0; i < 3; i++) m_ready[i] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    for (int i = 0; i < 3; i++) m_ready[i] = 1'b1;
    repeat (50) begin
      @(posedge clk); #2;
    end
    for (int i = 0; i < 3; i++) begin
      chk(i, "drain_pend", 32'(pend[i]), 32'd0);
      chk(i, "sb_balance", 32'(n_acc[i]), 32'(n_ret[i] + n_drop[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
